pi_so_serializer: RTL and testbench

Parallel-in/serial-out transmit stage that sits directly upstream of the serial-in/parallel-out shift register and drives its SI input. It accepts whole words over a valid/ready handshake, buffers one pending word, and shifts each word out one bit per clock, MSB first by default. It provides a frame strobe and an end-of-word pulse so the downstream stage can qualify or count bits.

---
 rtl/pi_so_pkg.sv | 9 +
 rtl/pi_so_serializer_if.sv | 23 ++
 rtl/pi_so_shift_core.sv | 38 +++
 rtl/pi_so_serializer.sv | 86 ++++++++
 tb/tb_pi_so_serializer.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_so_pkg.sv
// rtl/pi_so_pkg.sv - shared constants and state encoding for the serializer
package pi_so_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/pi_so_serializer_if.sv
// rtl/pi_so_serializer_if.sv - word handshake in, serial bit stream out
interface pi_so_serializer_if
  import pi_so_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             SO;
  logic             so_valid;
  logic             word_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, SO, so_valid, word_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, SO, so_valid, word_done
  );
endinterface

// File: rtl/pi_so_shift_core.sv
// rtl/pi_so_shift_core.sv - shift register and bit counter, flags the last bit
module pi_so_shift_core
  import pi_so_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_bit,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;

  // cnt saturates at the last bit; only a reload brings it back to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (shift && !last) begin
      sreg <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign out_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign last    = (cnt == LAST_CNT);
endmodule

// File: rtl/pi_so_serializer.sv
// rtl/pi_so_serializer.sv - one-word hold buffer, handshake and IDLE/SHIFT control
module pi_so_serializer
  import pi_so_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  pi_so_serializer_if.slave   bus
);
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;
  logic             load;
  logic             shift;
  logic             out_bit;
  logic             last;

  // ready comes straight from the hold flag, so a fill and a drain never share an edge
  assign accept = bus.in_valid && !hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= bus.in_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!last) begin
          shift = 1'b1;
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  pi_so_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (hold),
    .out_bit   (out_bit),
    .last      (last)
  );

  assign bus.in_ready  = !hold_full;
  assign bus.so_valid  = (state == SHIFT);
  assign bus.SO        = (state == SHIFT) && out_bit;
  assign bus.word_done = (state == SHIFT) && last;
endmodule

// File: tb/tb_pi_so_serializer.sv
// tb/tb_pi_so_serializer.sv - randomized and directed checks of MSB- and LSB-first serializers
module tb_pi_so_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pi_so_serializer_if #(.WIDTH(8)) ia ();
  pi_so_serializer_if #(.WIDTH(8)) ib ();

  pi_so_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  pi_so_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  int vectors = 0;
  int errors  = 0;
  int stalls  = 0;
  int bad_len_a, bad_len_b;
  logic [7:0] to_send[$];
  logic [7:0] sent_q[$];
  logic [7:0] words_a[$];
  logic [7:0] words_b[$];
  bit va_q[$], sa_q[$], da_q[$];
  bit vb_q[$], sb_q[$], db_q[$];

  task automatic set_in(input bit v, input logic [7:0] d);
    ia.in_valid = v;
    ia.in_data  = d;
    ib.in_valid = v;
    ib.in_data  = d;
  endtask

  task automatic tick();
    @(negedge clk);
    va_q.push_back(ia.so_valid);
    sa_q.push_back(ia.SO);
    da_q.push_back(ia.word_done);
    vb_q.push_back(ib.so_valid);
    sb_q.push_back(ib.SO);
    db_q.push_back(ib.word_done);
  endtask

  task automatic clear_rec();
    va_q.delete(); sa_q.delete(); da_q.delete();
    vb_q.delete(); sb_q.delete(); db_q.delete();
    sent_q.delete();
    stalls = 0;
  endtask

  // Presents each word of to_send, holding valid with junk data while not ready.
  task automatic send_words(input int max_gap, input int drain);
    int gap;
    bit accepted;
    foreach (to_send[i]) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        set_in(1'b0, 8'($urandom));
        tick();
      end
      accepted = 1'b0;
      for (int c = 0; c < 64; c++) begin
        if (ia.in_ready) begin
          set_in(1'b1, to_send[i]);
          sent_q.push_back(to_send[i]);
          tick();
          accepted = 1'b1;
          break;
        end
        set_in(1'b1, 8'($urandom));
        stalls++;
        tick();
      end
      if (!accepted) begin
        vectors++;
        errors++;
        $display("FAIL send_timeout word %0d: accepted=0 required=1", i);
      end
    end
    set_in(1'b0, 8'h00);
    repeat (drain) tick();
  endtask

  // Downstream SI_PO model: collects bits while so_valid, yields a word at each word_done.
  task automatic decode();
    logic [7:0] acc_a, acc_b;
    int n_a, n_b;
    acc_a = 8'h00; acc_b = 8'h00; n_a = 0; n_b = 0;
    bad_len_a = 0; bad_len_b = 0;
    words_a.delete(); words_b.delete();
    for (int i = 0; i < va_q.size(); i++) begin
      if (va_q[i]) begin
        acc_a = {acc_a[6:0], sa_q[i]};
        n_a++;
        if (da_q[i]) begin
          if (n_a != 8) bad_len_a++;
          words_a.push_back(acc_a);
          n_a = 0;
        end
      end
      if (vb_q[i]) begin
        acc_b = {sb_q[i], acc_b[7:1]};
        n_b++;
        if (db_q[i]) begin
          if (n_b != 8) bad_len_b++;
          words_b.push_back(acc_b);
          n_b = 0;
        end
      end
    end
    if (n_a != 0) bad_len_a++;
    if (n_b != 0) bad_len_b++;
  endtask

  task automatic test_reset();
    set_in(1'b1, 8'h55);
    repeat (2) @(negedge clk);
    vectors++;
    if ({ia.in_ready, ia.SO, ia.so_valid, ia.word_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_a: ready/so/valid/done=%b required 1000",
               {ia.in_ready, ia.SO, ia.so_valid, ia.word_done});
    end
    vectors++;
    if ({ib.in_ready, ib.SO, ib.so_valid, ib.word_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_b: ready/so/valid/done=%b required 1000",
               {ib.in_ready, ib.SO, ib.so_valid, ib.word_done});
    end
    set_in(1'b0, 8'h00);
    #2 rst = 1'b1;
    clear_rec();
    set_in(1'b1, 8'hFF);
    tick();
    set_in(1'b1, 8'hAA);
    repeat (4) tick();
    vectors++;
    if (ia.so_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_midword_busy: so_valid=%b required 1", ia.so_valid);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({ia.in_ready, ia.SO, ia.so_valid, ia.word_done, ib.in_ready, ib.SO, ib.so_valid, ib.word_done}
        !== 8'b1000_1000) begin
      errors++;
      $display("FAIL reset_async: a/b ready,so,valid,done=%b required 10001000",
               {ia.in_ready, ia.SO, ia.so_valid, ia.word_done,
                ib.in_ready, ib.SO, ib.so_valid, ib.word_done});
    end
    set_in(1'b0, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    clear_rec();
    repeat (12) tick();
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (va_q[k] !== 1'b0 || vb_q[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet cycle %0d: valid a/b=%b%b required 00", k, va_q[k], vb_q[k]);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hA5;
    bit ev, es_a, es_b, ed;
    clear_rec();
    to_send = '{8'hA5};
    send_words(0, 14);
    for (int k = 0; k < 12; k++) begin
      ev   = (k >= 1 && k <= 8);
      es_a = ev ? w[8-k] : 1'b0;
      es_b = ev ? w[k-1] : 1'b0;
      ed   = (k == 8);
      vectors++;
      if ({va_q[k], sa_q[k], da_q[k]} !== {ev, es_a, ed}) begin
        errors++;
        $display("FAIL single_msb cycle %0d: valid/so/done=%b%b%b required %b%b%b",
                 k, va_q[k], sa_q[k], da_q[k], ev, es_a, ed);
      end
      vectors++;
      if ({vb_q[k], sb_q[k], db_q[k]} !== {ev, es_b, ed}) begin
        errors++;
        $display("FAIL single_lsb cycle %0d: valid/so/done=%b%b%b required %b%b%b",
                 k, vb_q[k], sb_q[k], db_q[k], ev, es_b, ed);
      end
    end
  endtask

  task automatic test_lsb_first();
    bit ev, es;
    clear_rec();
    to_send = '{8'h01};
    send_words(0, 12);
    for (int k = 0; k < 10; k++) begin
      ev = (k >= 1 && k <= 8);
      es = (k == 1);
      vectors++;
      if ({vb_q[k], sb_q[k]} !== {ev, es}) begin
        errors++;
        $display("FAIL lsb_first cycle %0d: valid/so=%b%b required %b%b", k, vb_q[k], sb_q[k], ev, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] st = 16'hF00F;
    bit ev, es, ed;
    clear_rec();
    to_send = '{8'hF0, 8'h0F};
    send_words(0, 20);
    for (int k = 0; k < 19; k++) begin
      ev = (k >= 1 && k <= 16);
      es = ev ? st[16-k] : 1'b0;
      ed = (k == 8 || k == 16);
      vectors++;
      if ({va_q[k], sa_q[k], da_q[k]} !== {ev, es, ed}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: valid/so/done=%b%b%b required %b%b%b",
                 k, va_q[k], sa_q[k], da_q[k], ev, es, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_valid, first, last_i;
    clear_rec();
    to_send = '{8'h3C, 8'hC3, 8'h81};
    send_words(0, 30);
    vectors++;
    if (stalls !== 8) begin
      errors++;
      $display("FAIL backpressure_stalls: not-ready cycles=%0d required 8", stalls);
    end
    decode();
    vectors++;
    if (words_a.size() !== 3 || bad_len_a !== 0) begin
      errors++;
      $display("FAIL backpressure_count: words=%0d badlen=%0d required 3 and 0", words_a.size(), bad_len_a);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (words_a[i] !== to_send[i]) begin
          errors++;
          $display("FAIL backpressure_word %0d: PO=%h required %h", i, words_a[i], to_send[i]);
        end
      end
    end
    n_valid = 0; first = -1; last_i = -1;
    foreach (va_q[i]) if (va_q[i]) begin
      n_valid++;
      if (first < 0) first = i;
      last_i = i;
    end
    vectors++;
    if (n_valid !== 24 || (last_i - first + 1) !== 24) begin
      errors++;
      $display("FAIL backpressure_contig: valid=%0d span=%0d required 24 and 24", n_valid, last_i - first + 1);
    end
  endtask

  task automatic test_late_accept();
    logic [7:0] w1, w2;
    bit found;
    int mark;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    clear_rec();
    set_in(1'b1, w1);
    tick();
    set_in(1'b0, 8'h00);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (da_q[da_q.size()-1]) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL late_wait: word_done seen=0 required 1");
    end else begin
      vectors++;
      if (ia.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_ready: in_ready=%b required 1", ia.in_ready);
      end
      set_in(1'b1, w2);
      tick();
      set_in(1'b0, 8'h00);
      mark = va_q.size() - 1;
      repeat (10) tick();
      vectors++;
      if (va_q[mark] !== 1'b0) begin
        errors++;
        $display("FAIL late_gap: so_valid=%b required 0", va_q[mark]);
      end
      for (int j = 1; j <= 8; j++) begin
        vectors++;
        if ({va_q[mark+j], sa_q[mark+j]} !== {1'b1, w2[8-j]}) begin
          errors++;
          $display("FAIL late_bit %0d: valid/so=%b%b required 1%b", j, va_q[mark+j], sa_q[mark+j], w2[8-j]);
        end
      end
      vectors++;
      if (va_q[mark+9] !== 1'b0) begin
        errors++;
        $display("FAIL late_end: so_valid=%b required 0", va_q[mark+9]);
      end
    end
  endtask

  task automatic test_random();
    clear_rec();
    to_send.delete();
    repeat (24) to_send.push_back(8'($urandom));
    send_words(3, 30);
    decode();
    vectors++;
    if (words_a.size() !== sent_q.size() || bad_len_a !== 0) begin
      errors++;
      $display("FAIL random_count_a: words=%0d badlen=%0d required %0d and 0", words_a.size(), bad_len_a, sent_q.size());
    end else begin
      foreach (sent_q[i]) begin
        vectors++;
        if (words_a[i] !== sent_q[i]) begin
          errors++;
          $display("FAIL random_word_a %0d: PO=%h required %h", i, words_a[i], sent_q[i]);
        end
      end
    end
    vectors++;
    if (words_b.size() !== sent_q.size() || bad_len_b !== 0) begin
      errors++;
      $display("FAIL random_count_b: words=%0d badlen=%0d required %0d and 0", words_b.size(), bad_len_b, sent_q.size());
    end else begin
      foreach (sent_q[i]) begin
        vectors++;
        if (words_b[i] !== sent_q[i]) begin
          errors++;
          $display("FAIL random_word_b %0d: PO=%h required %h", i, words_b[i], sent_q[i]);
        end
      end
    end
  endtask

  initial begin
    set_in(1'b0, 8'h00);
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_backpressure();
    test_late_accept();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
